fsm_sequencer: RTL and testbench

//   Programmable state-machine engine: holds serially loaded config for a bank of N_STATE

---
 rtl/fsm_sequencer_pkg.sv | 21 ++
 rtl/fsm_sequencer_if.sv | 19 +
 rtl/fsm_sequencer_literal_mux.sv | 38 +++
 rtl/fsm_sequencer.sv | 125 ++++++++++++
 tb/tb_fsm_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_sequencer_pkg.sv
// Shared types and constants for the programmable state-machine sequencer.
// Holds the controller state encoding and the config-slot geometry helpers.
package fsm_sequencer_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_LOAD = 2'd1,
    CTRL_RUN  = 2'd2
  } ctrl_t;

  localparam int SLOTS_PER_UNIT = 6;

  // Constant select codes sit just above the state and ext_in ranges.
  localparam int SEL_CONST0_OFS = 0;
  localparam int SEL_CONST1_OFS = 1;

  function automatic int slot_w(input int sel_w);
    return sel_w + 1;
  endfunction

endpackage

// File: rtl/fsm_sequencer_if.sv
// Serial configuration port of fsm_sequencer: load handshake plus readback.
interface fsm_sequencer_if;
  logic cfg_start;
  logic cfg_bit;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_done;
  logic cfg_dout;

  modport master (
    output cfg_start, cfg_bit, cfg_valid,
    input  cfg_ready, cfg_done, cfg_dout
  );

  modport slave (
    input  cfg_start, cfg_bit, cfg_valid,
    output cfg_ready, cfg_done, cfg_dout
  );
endinterface

// File: rtl/fsm_sequencer_literal_mux.sv
// One configurable literal: selects a state bit, ext input or constant,
// then optionally inverts it.
module literal_mux
  import fsm_sequencer_pkg::*;
#(
  parameter int N_STATE = 4,
  parameter int N_IN    = 4,
  parameter int SEL_W   = 4
) (
  input  logic [SEL_W:0]     slot,
  input  logic [N_STATE-1:0] state,
  input  logic [N_IN-1:0]    ext,
  output logic               lit
);

  logic [SEL_W-1:0] sel;
  logic             inv;
  int unsigned      sel_i;
  logic             raw;

  assign sel = slot[SEL_W-1:0];
  assign inv = slot[SEL_W];

  // Codes above the const0 code all decode to const1.
  always_comb begin
    sel_i = 32'(sel);
    raw   = 1'b1;
    if (sel_i == N_STATE + N_IN + SEL_CONST0_OFS) raw = 1'b0;
    for (int unsigned i = 0; i < N_STATE; i++) begin
      if (sel_i == i) raw = state[i];
    end
    for (int unsigned j = 0; j < N_IN; j++) begin
      if (sel_i == N_STATE + j) raw = ext[j];
    end
    lit = raw ^ inv;
  end

endmodule

// File: rtl/fsm_sequencer.sv
// Programmable state-machine engine: serially loaded SOP config, one unit per state bit.
// Optional build macro FSM_SEQUENCER_READBACK_EN enables serial config readback on cfg_dout.
module fsm_sequencer
  import fsm_sequencer_pkg::*;
#(
  parameter int N_STATE = 4,
  parameter int N_IN    = 4,
  parameter int SEL_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  fsm_sequencer_if.slave      cfg,
  input  logic                run_en,
  input  logic [N_IN-1:0]     ext_in,
  output logic [N_STATE-1:0]  state_out,
  output logic                running
);

  localparam int SLOT_W   = slot_w(SEL_W);
  localparam int UNIT_W   = SLOTS_PER_UNIT * SLOT_W;
  localparam int CFG_BITS = N_STATE * UNIT_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  if ((1 << SEL_W) < N_STATE + N_IN + 2) begin : g_sel_w_check
    $error("SEL_W too small for N_STATE+N_IN+2 select codes");
  end

  ctrl_t                            ctrl, ctrl_nxt;
  logic [CFG_BITS-1:0]              cfg_q;
  logic [CNT_W-1:0]                 cnt;
  logic                             done_q;
  logic                             accept, last, step;
  logic [N_STATE*SLOTS_PER_UNIT-1:0] lits;
  logic [N_STATE-1:0]               next_state;

  // cfg_start outranks everything, so a bit offered alongside it is dropped.
  assign accept = (ctrl == CTRL_LOAD) && cfg.cfg_valid && !cfg.cfg_start;
  assign last   = accept && (cnt == CNT_W'(CFG_BITS - 1));
  assign step   = (ctrl == CTRL_RUN) && run_en && !cfg.cfg_start;

  always_ff @(posedge clk) begin
    if (reset) ctrl <= CTRL_IDLE;
    else       ctrl <= ctrl_nxt;
  end

  always_comb begin
    ctrl_nxt = ctrl;
    unique case (ctrl)
      CTRL_IDLE: begin
        if (cfg.cfg_start)          ctrl_nxt = CTRL_LOAD;
        else if (run_en && done_q)  ctrl_nxt = CTRL_RUN;
      end
      CTRL_LOAD: begin
        if (cfg.cfg_start) ctrl_nxt = CTRL_LOAD;
        else if (last)     ctrl_nxt = CTRL_IDLE;
      end
      CTRL_RUN: begin
        if (cfg.cfg_start) ctrl_nxt = CTRL_LOAD;
        else if (!run_en)  ctrl_nxt = CTRL_IDLE;
      end
      default: ctrl_nxt = CTRL_IDLE;
    endcase
  end

  always_comb begin
    cfg.cfg_ready = (ctrl == CTRL_LOAD);
    running       = (ctrl == CTRL_RUN);
  end

  assign cfg.cfg_done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (cfg.cfg_start) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (accept) begin
      cfg_q <= {cfg_q[CFG_BITS-2:0], cfg.cfg_bit};
      cnt   <= last ? '0 : cnt + CNT_W'(1);
      if (last) done_q <= 1'b1;
    end
  end

`ifdef FSM_SEQUENCER_READBACK_EN
  logic dout_q;

  // Captures the MSB before the shift, so a reload streams out the prior image.
  always_ff @(posedge clk) begin
    if (reset)       dout_q <= 1'b0;
    else if (accept) dout_q <= cfg_q[CFG_BITS-1];
  end

  assign cfg.cfg_dout = dout_q;
`else
  assign cfg.cfg_dout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)     state_out <= '0;
    else if (step) state_out <= next_state;
  end

  for (genvar u = 0; u < N_STATE; u++) begin : g_unit
    localparam int B = u * SLOTS_PER_UNIT;
    for (genvar k = 0; k < SLOTS_PER_UNIT; k++) begin : g_slot
      literal_mux #(
        .N_STATE (N_STATE),
        .N_IN    (N_IN),
        .SEL_W   (SEL_W)
      ) u_mux (
        .slot  (cfg_q[u*UNIT_W + k*SLOT_W +: SLOT_W]),
        .state (state_out),
        .ext   (ext_in),
        .lit   (lits[B + k])
      );
    end
    assign next_state[u] = (lits[B]   & lits[B+1]) |
                           (lits[B+2] & lits[B+3]) |
                           (lits[B+4] & lits[B+5]);
  end

endmodule

// File: tb/tb_fsm_sequencer.sv
// Self-checking bench for fsm_sequencer against a behavioural reference model.
module tb_fsm_sequencer;

  localparam int NS  = 4;
  localparam int NI  = 4;
  localparam int SW  = 4;
  localparam int SLW = SW + 1;
  localparam int CB  = NS * 6 * SLW;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          run_en = 1'b0;
  logic [NI-1:0] ext_in = '0;
  logic [NS-1:0] state_out;
  logic          running;

  int n_pass  = 0;
  int n_total = 0;

  int            m_mode = M_IDLE;
  int            m_cnt  = 0;
  bit            m_done = 1'b0;
  logic [CB-1:0] m_cfg  = '0;
  logic [NS-1:0] m_state = '0;
  logic          m_dout = 1'b0;

  fsm_sequencer_if cfg_if();

  fsm_sequencer #(
    .N_STATE (NS),
    .N_IN    (NI),
    .SEL_W   (SW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg       (cfg_if),
    .run_en    (run_en),
    .ext_in    (ext_in),
    .state_out (state_out),
    .running   (running)
  );

  always #5 clk = ~clk;

  function automatic logic ref_lit(logic [SLW-1:0] slot, logic [NS-1:0] s, logic [NI-1:0] e);
    int   sel;
    logic v;
    sel = int'(slot[SW-1:0]);
    if (sel < NS)           v = s[sel];
    else if (sel < NS + NI) v = e[sel - NS];
    else if (sel == NS + NI) v = 1'b0;
    else                    v = 1'b1;
    return v ^ slot[SW];
  endfunction

  function automatic logic [NS-1:0] ref_next(logic [CB-1:0] c, logic [NS-1:0] s, logic [NI-1:0] e);
    logic [NS-1:0] r;
    r = '0;
    for (int u = 0; u < NS; u++) begin
      for (int t = 0; t < 3; t++) begin
        if (ref_lit(c[u*6*SLW + (2*t)*SLW +: SLW], s, e) &&
            ref_lit(c[u*6*SLW + (2*t+1)*SLW +: SLW], s, e))
          r[u] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [CB-1:0] fill_img(logic [SLW-1:0] slot);
    logic [CB-1:0] img;
    for (int i = 0; i < NS * 6; i++) img[i*SLW +: SLW] = slot;
    return img;
  endfunction

  function automatic logic [CB-1:0] rand_img();
    logic [CB-1:0] img;
    for (int i = 0; i < CB; i++) img[i] = 1'($urandom);
    return img;
  endfunction

  task automatic model_step();
    logic [NS-1:0] nxt;
    nxt = ref_next(m_cfg, m_state, ext_in);
    if (reset) begin
      m_mode = M_IDLE; m_state = '0; m_cfg = '0; m_cnt = 0; m_done = 1'b0; m_dout = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (cfg_if.cfg_start) begin m_mode = M_LOAD; m_cnt = 0; m_done = 1'b0; end
          else if (run_en && m_done) m_mode = M_RUN;
        end
        M_LOAD: begin
          if (cfg_if.cfg_start) m_cnt = 0;
          else if (cfg_if.cfg_valid) begin
`ifdef FSM_SEQUENCER_READBACK_EN
            m_dout = m_cfg[CB-1];
`endif
            m_cfg = {m_cfg[CB-2:0], cfg_if.cfg_bit};
            m_cnt++;
            if (m_cnt == CB) begin m_mode = M_IDLE; m_done = 1'b1; m_cnt = 0; end
          end
        end
        default: begin
          if (cfg_if.cfg_start) begin m_mode = M_LOAD; m_cnt = 0; m_done = 1'b0; end
          else if (run_en) m_state = nxt;
          else m_mode = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_load(input logic [CB-1:0] img, input int gap);
    cfg_if.cfg_start = 1'b1;
    cycle();
    cfg_if.cfg_start = 1'b0;
    for (int b = CB - 1; b >= 0; b--) begin
      if (gap == 1 || (gap == 2 && $urandom_range(1, 0) == 1)) begin
        cfg_if.cfg_valid = 1'b0;
        cycle();
      end
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_bit   = img[b];
      cycle();
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    n_total++; if (state_out !== 4'b0000) $display("FAIL reset_state got %b want 0000", state_out); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else n_pass++;
    n_total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", cfg_if.cfg_ready); else n_pass++;
    n_total++; if (cfg_if.cfg_done !== 1'b0) $display("FAIL reset_done got %b want 0", cfg_if.cfg_done); else n_pass++;
    n_total++; if (cfg_if.cfg_dout !== 1'b0) $display("FAIL reset_dout got %b want 0", cfg_if.cfg_dout); else n_pass++;
  endtask

  task automatic test_run_without_cfg();
    run_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ext_in = 4'($urandom);
      cycle();
      n_total++; if (running !== 1'b0) $display("FAIL nocfg_running got %b want 0", running); else n_pass++;
      n_total++; if (state_out !== 4'b0000) $display("FAIL nocfg_state got %b want 0000", state_out); else n_pass++;
    end
    run_en = 1'b0;
  endtask

  task automatic test_const1();
    drive_load(fill_img(5'b0_1001), 0);
    n_total++; if (cfg_if.cfg_done !== 1'b1) $display("FAIL const1_done got %b want 1", cfg_if.cfg_done); else n_pass++;
    n_total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL const1_ready got %b want 0", cfg_if.cfg_ready); else n_pass++;
    run_en = 1'b1;
    cycle();
    n_total++; if (running !== 1'b1) $display("FAIL const1_running got %b want 1", running); else n_pass++;
    cycle();
    n_total++; if (state_out !== 4'b1111) $display("FAIL const1_state got %b want 1111", state_out); else n_pass++;
    run_en = 1'b0;
    cycle();
    n_total++; if (running !== 1'b0) $display("FAIL const1_stop got %b want 0", running); else n_pass++;
    n_total++; if (state_out !== 4'b1111) $display("FAIL const1_hold got %b want 1111", state_out); else n_pass++;
  endtask

  task automatic test_toggle();
    logic [CB-1:0] img;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    img = fill_img(5'b0_1000);
    img[0 +: SLW]   = 5'b1_0000;
    img[SLW +: SLW] = 5'b0_1001;
    drive_load(img, 0);
    run_en = 1'b1;
    cycle();
    for (int k = 0; k < 6; k++) begin
      ext_in = 4'($urandom);
      cycle();
      n_total++;
      if (state_out[0] !== ((k % 2) == 0)) $display("FAIL toggle_bit0 step %0d got %b want %b", k, state_out[0], (k % 2) == 0);
      else n_pass++;
      n_total++;
      if (state_out[3:1] !== 3'b000) $display("FAIL toggle_upper step %0d got %b want 000", k, state_out[3:1]);
      else n_pass++;
    end
    run_en = 1'b0;
    cycle();
  endtask

  task automatic test_gapped();
    logic [CB-1:0] img;
    int acc;
    int guard;
    img = rand_img();
    cfg_if.cfg_start = 1'b1;
    cycle();
    cfg_if.cfg_start = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < CB && guard < 4 * CB) begin
      cfg_if.cfg_valid = (guard % 2 == 1);
      cfg_if.cfg_bit   = img[CB - 1 - acc];
      cycle();
      if (cfg_if.cfg_valid) acc++;
      guard++;
      n_total++;
      if (cfg_if.cfg_done !== (acc == CB)) $display("FAIL gapped_done accepts %0d got %b want %b", acc, cfg_if.cfg_done, acc == CB);
      else n_pass++;
      n_total++;
      if (cfg_if.cfg_ready !== (acc < CB)) $display("FAIL gapped_ready accepts %0d got %b want %b", acc, cfg_if.cfg_ready, acc < CB);
      else n_pass++;
    end
    cfg_if.cfg_valid = 1'b0;
    n_total++; if (acc != CB) $display("FAIL gapped_budget got %0d want %0d", acc, CB); else n_pass++;
  endtask

  task automatic test_restart();
    logic [NS-1:0] held;
    held = state_out;
    run_en = 1'b1;
    cfg_if.cfg_start = 1'b1;
    cycle();
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cfg_if.cfg_bit = 1'($urandom);
      cycle();
    end
    cfg_if.cfg_start = 1'b1;
    cycle();
    cfg_if.cfg_start = 1'b0;
    n_total++; if (cfg_if.cfg_done !== 1'b0) $display("FAIL restart_done got %b want 0", cfg_if.cfg_done); else n_pass++;
    n_total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL restart_ready got %b want 1", cfg_if.cfg_ready); else n_pass++;
    for (int i = 0; i < CB; i++) begin
      cfg_if.cfg_bit = 1'($urandom);
      cycle();
      n_total++;
      if (cfg_if.cfg_done !== (i == CB - 1)) $display("FAIL restart_count accept %0d got %b want %b", i, cfg_if.cfg_done, i == CB - 1);
      else n_pass++;
      n_total++;
      if (running !== 1'b0 || state_out !== held) $display("FAIL restart_hold accept %0d got %b/%b want 0/%b", i, running, state_out, held);
      else n_pass++;
    end
    cfg_if.cfg_valid = 1'b0;
    run_en = 1'b0;
  endtask

  task automatic test_random_run();
    for (int rep = 0; rep < 3; rep++) begin
      drive_load(rand_img(), 2);
      for (int i = 0; i < 40; i++) begin
        run_en = ($urandom_range(3, 0) != 0);
        ext_in = 4'($urandom);
        cycle();
        n_total++;
        if (state_out !== m_state) $display("FAIL random_state rep %0d cyc %0d got %b want %b", rep, i, state_out, m_state);
        else n_pass++;
        n_total++;
        if (running !== (m_mode == M_RUN)) $display("FAIL random_running rep %0d cyc %0d got %b want %b", rep, i, running, m_mode == M_RUN);
        else n_pass++;
      end
      run_en = 1'b0;
      cycle();
    end
  endtask

  task automatic test_readback();
    logic [CB-1:0] a;
    logic          exp;
    a = rand_img();
    drive_load(a, 0);
    cfg_if.cfg_start = 1'b1;
    cycle();
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    for (int k = 0; k < CB; k++) begin
      cfg_if.cfg_bit = 1'($urandom);
      cycle();
`ifdef FSM_SEQUENCER_READBACK_EN
      exp = a[CB - 1 - k];
`else
      exp = 1'b0;
`endif
      n_total++;
      if (cfg_if.cfg_dout !== exp) $display("FAIL readback bit %0d got %b want %b", k, cfg_if.cfg_dout, exp);
      else n_pass++;
    end
    cfg_if.cfg_valid = 1'b0;
    cycle();
  endtask

  initial begin
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_bit   = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    test_reset();
    test_run_without_cfg();
    test_const1();
    test_toggle();
    test_gapped();
    test_restart();
    test_random_run();
    test_readback();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
